// File: rtl/gb_dma_pkg.sv
// Shared types and constants for the OAM DMA controller.
package gb_dma_pkg;

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  localparam int         OAM_LEN    = 160;
  localparam logic [7:0] ECHO_BASE  = 8'hE0;
  localparam logic [7:0] ECHO_OFS   = 8'h20;
  localparam logic [1:0] PH_RD_LAST = 2'd2;
  localparam logic [1:0] PH_WR      = 2'd3;

  // Pages E0..FF mirror work RAM at C0..DF.
  function automatic logic [7:0] src_fold(input logic [7:0] s);
    return (s >= ECHO_BASE) ? s - ECHO_OFS : s;
  endfunction

endpackage

// File: rtl/gb_oam_dma_if.sv
// DMA-side bus: external source read port, video-side OAM write port and the bus-steer flag.
interface gb_oam_dma_if;
  logic [15:0] adr_dma;
  logic        rd_dma;
  logic [7:0]  data_ext;
  logic [7:0]  oam_adr;
  logic [7:0]  oam_dout;
  logic        wr_oam;
  logic        active;

  modport master (
    output adr_dma, rd_dma, oam_adr, oam_dout, wr_oam, active,
    input  data_ext
  );

  modport slave (
    input  adr_dma, rd_dma, oam_adr, oam_dout, wr_oam, active,
    output data_ext
  );
endinterface

// File: rtl/gb_oam_dma.sv
// FF46 OAM DMA: copies LEN bytes from {src,00} into OAM, one byte per M-cycle.
module gb_oam_dma
  import gb_dma_pkg::*;
#(
  parameter int LEN  = OAM_LEN,
  parameter int MCYC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  input  logic            read,
  input  logic            write,
  input  logic            sel,
  gb_oam_dma_if.master    bus
);

  localparam logic [1:0] PH_END   = 2'(MCYC - 1);
  localparam logic [7:0] IDX_LAST = 8'(LEN - 1);

  state_t     state, state_n;
  logic [7:0] src;
  logic [7:0] idx;
  logic [7:0] hi;
  logic [7:0] oam_q;
  logic [1:0] ph;
  logic       reg_wr;
  logic       mcyc_end;
  logic       byte_last;
  logic       xfer_rd;
  logic       xfer_wr;

  // Readback is unconditional; the strobe only qualifies it at the io mux.
  logic unused_read;
  assign unused_read = read;

  assign reg_wr    = write & sel;
  assign mcyc_end  = (ph == PH_END);
  assign byte_last = (idx == IDX_LAST);
  assign hi        = src_fold(src);

  always_comb begin
    state_n = state;
    if (reg_wr) begin
      state_n = START;
    end else begin
      case (state)
        START:   if (mcyc_end) state_n = XFER;
        XFER:    if (mcyc_end && byte_last) state_n = IDLE;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src   <= 8'hFF;
      ph    <= 2'd0;
      idx   <= 8'd0;
      oam_q <= 8'd0;
    end else begin
      if (reg_wr) src <= din;

      // Any write (fresh or restart) rewinds both counters.
      if (reg_wr) begin
        ph  <= 2'd0;
        idx <= 8'd0;
      end else if (state != IDLE) begin
        ph <= ph + 2'd1;
        if (state == XFER && mcyc_end)
          idx <= byte_last ? 8'd0 : idx + 8'd1;
      end

      if (state == XFER && ph == PH_RD_LAST) oam_q <= bus.data_ext;
    end
  end

  assign xfer_rd = (state == XFER) && (ph <= PH_RD_LAST);
  assign xfer_wr = (state == XFER) && (ph == PH_WR);

  assign bus.rd_dma   = xfer_rd;
  assign bus.wr_oam   = xfer_wr;
  assign bus.adr_dma  = (state == XFER) ? {hi, idx} : 16'h0000;
  assign bus.oam_adr  = xfer_wr ? idx   : 8'h00;
  assign bus.oam_dout = xfer_wr ? oam_q : 8'h00;
  assign bus.active   = (state != IDLE);
  assign dout         = src;

endmodule

// File: tb/tb_gb_oam_dma.sv
// Directed + randomized bench for gb_oam_dma against a cycle-count timing model.
module tb_gb_oam_dma;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       read  = 1'b0;
  logic       write = 1'b0;
  logic       sel   = 1'b0;
  logic [7:0] din   = 8'h00;
  logic [7:0] dout;
  logic [7:0] key   = 8'h5A;

  gb_oam_dma_if bus();

  // Bus model: source byte = low address byte XOR key.
  assign bus.data_ext = bus.adr_dma[7:0] ^ key;

  gb_oam_dma dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .dout  (dout),
    .read  (read),
    .write (write),
    .sel   (sel),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int         n_chk    = 0;
  int         n_pass   = 0;
  int         m_t      = 0;     // clocks since the capturing edge, minus one
  bit         m_active = 1'b0;
  logic [7:0] m_src    = 8'hFF;
  int         wr_cnt   = 0;
  int         act_cnt  = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] fold(input logic [7:0] v);
    return (v >= 8'hE0) ? v - 8'h20 : v;
  endfunction

  task automatic step(input logic w, input logic s, input logic [7:0] d, input logic r);
    int         n;
    int         p;
    logic [7:0] hi;
    @(negedge clk);
    reset = r; write = w; sel = s; din = d; read = 1'b1;
    @(posedge clk);
    if (r) begin
      m_active = 1'b0;
      m_src    = 8'hFF;
    end else if (w && s) begin
      m_src    = d;
      m_active = 1'b1;
      m_t      = 0;
      wr_cnt   = 0;
      act_cnt  = 0;
    end else if (m_active) begin
      m_t++;
      if (m_t == 4 + 4 * 160) m_active = 1'b0;
    end
    #1;
    if (bus.wr_oam) wr_cnt++;
    if (bus.active) act_cnt++;
    chk("active", 16'(bus.active), 16'(m_active));
    chk("dout", 16'(dout), 16'(m_src));
    hi = fold(m_src);
    if (m_active && m_t >= 4) begin
      n = (m_t - 4) / 4;
      p = (m_t - 4) % 4;
      chk("rd_dma", 16'(bus.rd_dma), 16'(p < 3));
      chk("wr_oam", 16'(bus.wr_oam), 16'(p == 3));
      if (p < 3) begin
        chk("adr_dma", bus.adr_dma, {hi, 8'(n)});
      end else begin
        chk("oam_adr", 16'(bus.oam_adr), 16'(n));
        chk("oam_dout", 16'(bus.oam_dout), 16'(8'(n) ^ key));
      end
    end else begin
      chk("rd_dma_quiet", 16'(bus.rd_dma), 16'h0);
      chk("wr_oam_quiet", 16'(bus.wr_oam), 16'h0);
      if (!m_active) chk("adr_dma_idle", bus.adr_dma, 16'h0000);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic run_to(input int t);
    for (int i = 0; i < 700; i++) begin
      if (!m_active || m_t >= t) break;
      step(1'b0, 1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic run_done();
    for (int i = 0; i < 700; i++) begin
      if (!m_active) break;
      step(1'b0, 1'b0, 8'h00, 1'b0);
    end
    chk("wr_pulses", 16'(wr_cnt), 16'd160);
    chk("active_len", 16'(act_cnt), 16'd644);
  endtask

  initial begin
    // Reset state.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    idle(2);

    // Plain transfer from C100.
    key = 8'h5A;
    step(1'b1, 1'b1, 8'hC1, 1'b0);
    run_done();
    idle(3);

    // Strobes without sel are ignored; echo page folds to C3xx.
    step(1'b1, 1'b0, 8'(($urandom)), 1'b0);
    step(1'b1, 1'b0, 8'(($urandom)), 1'b0);
    key = 8'($urandom);
    step(1'b1, 1'b1, 8'hE3, 1'b0);
    run_done();
    idle(2);

    // Random source pages and bus contents.
    for (int k = 0; k < 2; k++) begin
      key = 8'($urandom);
      step(1'b1, 1'b1, 8'($urandom), 1'b0);
      run_done();
      idle(1 + int'($urandom_range(3)));
    end

    // Restart at byte 50 keeps active continuous.
    key = 8'h5A;
    step(1'b1, 1'b1, 8'h80, 1'b0);
    run_to(4 + 4 * 50);
    step(1'b1, 1'b1, 8'h90, 1'b0);
    run_done();
    idle(2);

    // Reset at byte 77, then quiet bus.
    key = 8'($urandom);
    step(1'b1, 1'b1, 8'($urandom), 1'b0);
    run_to(4 + 4 * 77 + 1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    wr_cnt = 0;
    idle(20);
    chk("no_wr_after_reset", 16'(wr_cnt), 16'd0);

    // Reset wins over a simultaneous write.
    step(1'b1, 1'b1, 8'h42, 1'b0);
    run_to(30);
    step(1'b1, 1'b1, 8'h55, 1'b1);
    idle(5);

    // Write coincident with the last ph3 restarts after byte 159 lands.
    key = 8'($urandom);
    step(1'b1, 1'b1, 8'($urandom), 1'b0);
    run_to(643);
    chk("last_wr_pulses", 16'(wr_cnt), 16'd160);
    chk("last_active_len", 16'(act_cnt), 16'd644);
    step(1'b1, 1'b1, 8'($urandom), 1'b0);
    run_done();
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
